data_cache: RTL and testbench
=============================

DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 Parameter LINES, default 64, number of direct-mapped lines (power of two, >= 2).
REQ-002 Parameter WORDS, default 4, 32-bit words per line (power of two, >= 2).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 cpu_re  input  1  load request from the MEM stage.
REQ-006 cpu_we  input  1  store request from the MEM stage.
REQ-007 cpu_addr  input  32  byte address; bits [1:0] ignored.
REQ-008 cpu_wdata  input  32  store data.
REQ-009 cpu_rdata  output  32  load data, combinational.
REQ-010 cache_stall  output  1  freezes all CPU pipeline registers while high.
REQ-011 mem_re  output  1  backing-memory word read request.
REQ-012 mem_we  output  1  backing-memory word write request.
REQ-013 mem_addr  output  32  word-aligned backing-memory address.
REQ-014 mem_wdata  output  32  write-back data.
REQ-015 mem_rdata  input  32  refill data, valid when mem_ack is high.
REQ-016 mem_ack  input  1  completes the current word transfer at the rising edge.

Function
REQ-017 Address split: offset = addr[log2(WORDS)+1:2], index = next log2(LINES) bits, tag = remaining upper bits.
REQ-018 Hit = valid[index] and tag match and state IDLE; hit evaluation is combinational in the request cycle.
REQ-019 Load hit: cpu_rdata = addressed word in the same cycle; cache_stall = 0.
REQ-020 Store hit: word written at the rising edge; dirty[index] set; cache_stall = 0.
REQ-021 Miss (cpu_re or cpu_we, not a hit): cache_stall = 1 combinationally in the same cycle; it stays high until the request hits.
REQ-022 CPU holds cpu_re, cpu_we, cpu_addr and cpu_wdata stable while cache_stall is high; the cache does not latch them.
REQ-023 FSM states: IDLE, WRITEBACK, REFILL.
REQ-024 IDLE -> WRITEBACK on a miss with the victim valid and dirty; IDLE -> REFILL on a miss with a clean or invalid victim.
REQ-025 WRITEBACK writes the victim words 0..WORDS-1 in order.
  - mem_we = 1; mem_addr = {victim tag, index, word counter, 2'b00}.
  - Counter advances on each mem_ack.
  - On the last ack: clear dirty and go to REFILL.
REQ-026 REFILL reads words 0..WORDS-1 in order.
  - mem_re = 1; mem_addr = {request tag, index, counter, 2'b00}.
  - Each mem_ack writes mem_rdata into the line.
  - On the last ack: set valid, write the tag, clear dirty, go to IDLE.
REQ-027 After refill, the request hits in IDLE on the next cycle and cache_stall drops in that cycle.
  - Clean miss: stall lasts WORDS acks + 1 cycle.
  - Dirty miss: stall lasts 2*WORDS acks + 1 cycle.
REQ-028 mem_re and mem_we are never high together; both are 0 in IDLE; mem_addr and mem_wdata hold stable until mem_ack.
REQ-029 mem_ack in IDLE is ignored; mem_ack may arrive in the first cycle of a request (zero-wait memory).
REQ-030 cpu_re and cpu_we both high: treated as a store.
REQ-031 Write-allocate: a store miss refills first, then the store completes as a hit in the cycle cache_stall is low.
REQ-032 cpu_rdata = 0 when there is no load hit.
REQ-033 Word counter wraps to 0 at each state exit.

Reset
REQ-034 rst low (asynchronous): state = IDLE, counter = 0, all valid and dirty bits = 0.
  - Outputs immediately: mem_re = mem_we = 0, cache_stall follows REQ-021.
REQ-035 Reset mid-WRITEBACK or mid-REFILL abandons the transfer; no partial line becomes valid.
REQ-036 Tag and data arrays are not reset.

Structure
REQ-037 Shared package holds: FSM state encoding, address-field width constants derived from LINES and WORDS.
REQ-038 One sub-module, dcache_array: tag/valid/dirty/data storage with a combinational read port and a synchronous write port.
REQ-039 FSM, counter and hit logic live in data_cache.

Verification
REQ-040 Cold load 0x0000_0100, memory returns 0x11,0x22,0x33,0x44 with 1-cycle acks -> 4 mem_re reads at 0x100..0x10C, stall 5 cycles, cpu_rdata = 0x11.
REQ-041 Store 0xDEAD_BEEF to 0x104 (after REQ-040) -> no stall, no memory traffic; load 0x104 -> 0xDEADBEEF.
REQ-042 Load 0x0000_0500 (same index, LINES=64) -> 4 writes at 0x100..0x10C with data 0x11,0xDEADBEEF,0x33,0x44, then 4 reads at 0x500..; stall 9 cycles.
REQ-043 Memory with 3 wait cycles per ack -> mem_addr/mem_re stable for 3 cycles per word; stall ends 1 cycle after the 4th ack.
REQ-044 rst low during the 2nd refill word -> mem_re = 0 immediately; after release, the same load misses again and refills all 4 words.
REQ-045 cpu_re = cpu_we = 1 to a miss address -> write-allocate refill, then store written, dirty set, cpu_rdata = 0.

Source files
------------

// File: rtl/data_cache_pkg.sv
// Shared definitions for the direct-mapped write-back data cache: FSM encoding
// and the address-field widths that follow from the line count and line size.
package data_cache_pkg;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int LINES_DEF = 64;
    localparam int WORDS_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_REFILL    = 2'd2
    } dc_state_e;

    function automatic int off_bits(input int words);
        return $clog2(words);
    endfunction

    function automatic int idx_bits(input int lines);
        return $clog2(lines);
    endfunction

    // Byte-offset bits [1:0] are never part of offset, index or tag.
    function automatic int tag_bits(input int lines, input int words);
        return ADDR_W - 2 - $clog2(lines) - $clog2(words);
    endfunction

    localparam int OFF_W_DEF = off_bits(WORDS_DEF);
    localparam int IDX_W_DEF = idx_bits(LINES_DEF);
    localparam int TAG_W_DEF = tag_bits(LINES_DEF, WORDS_DEF);

endpackage

// File: rtl/data_cache_if.sv
// CPU-side and memory-side signals of the data cache, bundled for port lists.
interface data_cache_if;

    logic        cpu_re;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cache_stall;
    logic        mem_re;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport slave (
        input  cpu_re, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
        output cpu_rdata, cache_stall, mem_re, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output cpu_re, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
        input  cpu_rdata, cache_stall, mem_re, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/data_cache_array.sv
// Tag/valid/dirty/data storage for the cache: combinational read of one line,
// synchronous word write plus line-state updates on the rising edge.
module dcache_array
    import data_cache_pkg::*;
#(
    parameter  int LINES = LINES_DEF,
    parameter  int WORDS = WORDS_DEF,
    localparam int OFF_W = off_bits(WORDS),
    localparam int IDX_W = idx_bits(LINES),
    localparam int TAG_W = tag_bits(LINES, WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [OFF_W-1:0]  rd_word_i,
    output logic              rd_valid_o,
    output logic              rd_dirty_o,
    output logic [TAG_W-1:0]  rd_tag_o,
    output logic [DATA_W-1:0] rd_data_o,
    input  logic              wr_en_i,
    input  logic [OFF_W-1:0]  wr_word_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              set_dirty_i,
    input  logic              clr_dirty_i,
    input  logic              fill_done_i,
    input  logic [TAG_W-1:0]  fill_tag_i
);

    logic [LINES-1:0]  valid_q;
    logic [LINES-1:0]  dirty_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [DATA_W-1:0] data_q [LINES*WORDS];

    assign rd_valid_o = valid_q[idx_i];
    assign rd_dirty_o = dirty_q[idx_i];
    assign rd_tag_o   = tag_q[idx_i];
    assign rd_data_o  = data_q[{idx_i, rd_word_i}];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_done_i) begin
            valid_q[idx_i] <= 1'b1;
            dirty_q[idx_i] <= 1'b0;
        end else if (set_dirty_i) begin
            dirty_q[idx_i] <= 1'b1;
        end else if (clr_dirty_i) begin
            dirty_q[idx_i] <= 1'b0;
        end
    end

    // Tags and data carry no reset; valid gates every use of them.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            data_q[{idx_i, wr_word_i}] <= wr_data_i;
        end
        if (fill_done_i) begin
            tag_q[idx_i] <= fill_tag_i;
        end
    end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-back, write-allocate data cache with a one-word memory port.
//   state        | meaning
//   ST_IDLE      | serving hits; a miss picks WRITEBACK (dirty victim) or REFILL
//   ST_WRITEBACK | streaming victim words 0..WORDS-1 out, one per mem_ack
//   ST_REFILL    | fetching requested line words 0..WORDS-1, one per mem_ack
module data_cache
    import data_cache_pkg::*;
#(
    parameter int LINES = LINES_DEF,
    parameter int WORDS = WORDS_DEF
) (
    input logic         clk,
    input logic         rst,
    data_cache_if.slave bus
);

    localparam int OFF_W = off_bits(WORDS);
    localparam int IDX_W = idx_bits(LINES);
    localparam int TAG_W = tag_bits(LINES, WORDS);
    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS - 1);

    dc_state_e state_q;
    logic [OFF_W-1:0] cnt_q;

    logic [OFF_W-1:0]  req_off;
    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic              line_valid;
    logic              line_dirty;
    logic [TAG_W-1:0]  line_tag;
    logic [DATA_W-1:0] line_word;
    logic              req, hit, miss, store_hit, load_hit;
    logic              in_wb, in_rf, last_ack;
    logic [OFF_W-1:0]  rd_word, wr_word;
    logic [DATA_W-1:0] wr_data;
    logic              wr_en;
    logic              addr_lsb_unused;

    assign addr_lsb_unused = ^bus.cpu_addr[1:0];

    assign req_off = bus.cpu_addr[OFF_W+1:2];
    assign req_idx = bus.cpu_addr[IDX_W+OFF_W+1:OFF_W+2];
    assign req_tag = bus.cpu_addr[ADDR_W-1:IDX_W+OFF_W+2];

    assign in_wb    = (state_q == ST_WRITEBACK);
    assign in_rf    = (state_q == ST_REFILL);
    assign last_ack = bus.mem_ack && (cnt_q == LAST_WORD);

    // A simultaneous load+store is a store, so it never returns load data.
    assign req       = bus.cpu_re | bus.cpu_we;
    assign hit       = req && (state_q == ST_IDLE) && line_valid && (line_tag == req_tag);
    assign miss      = req && !hit;
    assign store_hit = hit && bus.cpu_we;
    assign load_hit  = hit && bus.cpu_re && !bus.cpu_we;

    assign rd_word = in_wb ? cnt_q : req_off;
    assign wr_word = in_rf ? cnt_q : req_off;
    assign wr_data = in_rf ? bus.mem_rdata : bus.cpu_wdata;
    assign wr_en   = store_hit || (in_rf && bus.mem_ack);

    assign bus.cpu_rdata   = load_hit ? line_word : '0;
    assign bus.cache_stall = miss;
    assign bus.mem_we      = in_wb;
    assign bus.mem_re      = in_rf;
    assign bus.mem_wdata   = in_wb ? line_word : '0;
    assign bus.mem_addr    = in_wb ? {line_tag, req_idx, cnt_q, 2'b00} :
                             in_rf ? {req_tag,  req_idx, cnt_q, 2'b00} : '0;

    dcache_array #(
        .LINES (LINES),
        .WORDS (WORDS)
    ) u_array (
        .clk         (clk),
        .rst         (rst),
        .idx_i       (req_idx),
        .rd_word_i   (rd_word),
        .rd_valid_o  (line_valid),
        .rd_dirty_o  (line_dirty),
        .rd_tag_o    (line_tag),
        .rd_data_o   (line_word),
        .wr_en_i     (wr_en),
        .wr_word_i   (wr_word),
        .wr_data_i   (wr_data),
        .set_dirty_i (store_hit),
        .clr_dirty_i (in_wb && last_ack),
        .fill_done_i (in_rf && last_ack),
        .fill_tag_i  (req_tag)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (miss) begin
                        state_q <= (line_valid && line_dirty) ? ST_WRITEBACK : ST_REFILL;
                    end
                end
                ST_WRITEBACK: begin
                    if (last_ack) begin
                        cnt_q   <= '0;
                        state_q <= ST_REFILL;
                    end else if (bus.mem_ack) begin
                        cnt_q <= cnt_q + OFF_W'(1);
                    end
                end
                ST_REFILL: begin
                    if (last_ack) begin
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else if (bus.mem_ack) begin
                        cnt_q <= cnt_q + OFF_W'(1);
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_cache.sv
// Randomised check of data_cache against a line-level cache/memory model,
// plus directed sequences with literal expectations.
module tb_data_cache;

    localparam int LINES  = 64;
    localparam int WORDS  = 4;
    localparam int BUDGET = 300;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        int          wait_c;
    } op_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    data_cache_if bus();

    data_cache #(.LINES(LINES), .WORDS(WORDS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    bit          m_valid [LINES];
    bit          m_dirty [LINES];
    logic [31:0] m_tag   [LINES];
    logic [31:0] m_data  [LINES][WORDS];
    logic [31:0] mem [logic [31:0]];
    op_t         ops[$];
    wr_t         wlog[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] laddr(input logic [31:0] tag, input int idx, input int w);
        return tag * 32'(4 * WORDS * LINES) + 32'(idx * 4 * WORDS) + 32'(w * 4);
    endfunction

    function automatic int pick_wait(input int mode);
        return (mode < 0) ? int'($urandom_range(0, 3)) : mode;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < LINES; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.cpu_re    = 1'b0;
            bus.cpu_we    = 1'b0;
            bus.mem_ack   = 1'($urandom_range(0, 1));
            bus.mem_rdata = $urandom;
            #1;
            check(!bus.cache_stall, "idle_stall", 32'(bus.cache_stall), 32'h0);
            check(!bus.mem_re && !bus.mem_we, "idle_mem", {30'h0, bus.mem_re, bus.mem_we}, 32'h0);
            check(bus.cpu_rdata == 32'h0, "idle_rdata", bus.cpu_rdata, 32'h0);
        end
    endtask

    // One CPU request held until the cache stops stalling; memory side answered
    // from the expected transfer list with per-word wait cycles.
    task automatic do_req(input bit re, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                          input int wmode, input int abort_acks,
                          output int stall_o, output logic [31:0] rdata_o);
        int          idx, off, exp_stall, wl, acks, cyc;
        logic [31:0] tag, a, exp_rdata;
        logic [31:0] nl [WORDS];
        bit          hit, done, aborted;

        idx = int'((addr / 32'(4 * WORDS)) % 32'(LINES));
        off = int'((addr / 32'd4) % 32'(WORDS));
        tag = addr / 32'(4 * WORDS * LINES);
        hit = m_valid[idx] && (m_tag[idx] == tag);
        ops.delete();
        wlog.delete();
        exp_stall = 0;
        for (int w = 0; w < WORDS; w++) nl[w] = m_data[idx][w];
        if (!hit) begin
            if (m_valid[idx] && m_dirty[idx]) begin
                for (int w = 0; w < WORDS; w++) begin
                    a = laddr(m_tag[idx], idx, w);
                    ops.push_back('{1'b1, a, m_data[idx][w], pick_wait(wmode)});
                    mem[a] = m_data[idx][w];
                end
            end
            for (int w = 0; w < WORDS; w++) begin
                a = laddr(tag, idx, w);
                if (!mem.exists(a)) mem[a] = $urandom;
                nl[w] = mem[a];
                ops.push_back('{1'b0, a, nl[w], pick_wait(wmode)});
            end
            exp_stall = 1;
            foreach (ops[i]) exp_stall += ops[i].wait_c + 1;
        end
        exp_rdata = we ? 32'h0 : nl[off];

        @(negedge clk);
        bus.cpu_re    = re;
        bus.cpu_we    = we;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wdata;
        bus.mem_ack   = 1'b0;
        stall_o = 0; rdata_o = 32'h0;
        acks = 0; cyc = 0; wl = -1; done = 1'b0; aborted = 1'b0;

        while (!done && cyc <= BUDGET) begin
            #1;
            check(!(bus.mem_re && bus.mem_we), "mem_excl", {30'h0, bus.mem_re, bus.mem_we}, 32'h0);
            if (!bus.cache_stall) begin
                bus.mem_ack = 1'b0;
                rdata_o = bus.cpu_rdata;
                check(ops.size() == 0, "xfers_left", 32'(ops.size()), 32'h0);
                check(stall_o == exp_stall, "stall_len", 32'(stall_o), 32'(exp_stall));
                check(bus.cpu_rdata == exp_rdata, "rdata", bus.cpu_rdata, exp_rdata);
                check(!bus.mem_re && !bus.mem_we, "hit_mem", {30'h0, bus.mem_re, bus.mem_we}, 32'h0);
                done = 1'b1;
            end else begin
                stall_o++;
                if (abort_acks >= 0 && acks == abort_acks && bus.mem_re) begin
                    bus.mem_ack = 1'b0;
                    rst = 1'b0;
                    #1;
                    check(!bus.mem_re, "rst_mem_re", 32'(bus.mem_re), 32'h0);
                    check(!bus.mem_we, "rst_mem_we", 32'(bus.mem_we), 32'h0);
                    check(bus.cache_stall, "rst_stall", 32'(bus.cache_stall), 32'h1);
                    bus.cpu_re = 1'b0;
                    bus.cpu_we = 1'b0;
                    aborted = 1'b1;
                    done = 1'b1;
                end else if (bus.mem_re || bus.mem_we) begin
                    if (ops.size() == 0) begin
                        check(1'b0, "extra_xfer", bus.mem_addr, 32'h0);
                        bus.mem_ack = 1'b1;
                    end else begin
                        check(bus.mem_we == ops[0].wr, "xfer_kind", 32'(bus.mem_we), 32'(ops[0].wr));
                        check(bus.mem_addr == ops[0].addr, "xfer_addr", bus.mem_addr, ops[0].addr);
                        if (ops[0].wr)
                            check(bus.mem_wdata == ops[0].data, "wb_data", bus.mem_wdata, ops[0].data);
                        if (wl < 0) wl = ops[0].wait_c;
                        if (wl == 0) begin
                            bus.mem_ack   = 1'b1;
                            bus.mem_rdata = ops[0].wr ? $urandom : ops[0].data;
                            if (ops[0].wr) wlog.push_back('{bus.mem_addr, bus.mem_wdata});
                            void'(ops.pop_front());
                            acks++;
                            wl = -1;
                        end else begin
                            wl--;
                            bus.mem_ack   = 1'b0;
                            bus.mem_rdata = $urandom;
                        end
                    end
                end else begin
                    bus.mem_ack   = 1'($urandom_range(0, 1));
                    bus.mem_rdata = $urandom;
                end
            end
            cyc++;
            if (!done) @(negedge clk);
        end
        check(cyc <= BUDGET, "req_budget", 32'(cyc), 32'(BUDGET));
        bus.mem_ack = 1'b0;

        if (aborted) begin
            @(negedge clk);
            rst = 1'b1;
            model_reset();
        end else if (re || we) begin
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tag;
            if (!hit) m_dirty[idx] = 1'b0;
            for (int w = 0; w < WORDS; w++) m_data[idx][w] = nl[w];
            if (we) begin
                m_data[idx][off] = wdata;
                m_dirty[idx]     = 1'b1;
            end
        end
    endtask

    initial begin
        int          st;
        logic [31:0] rd, addr;
        int          sel;

        bus.cpu_re = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h0; bus.cpu_wdata = 32'h0;
        bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
        model_reset();

        repeat (3) @(negedge clk);
        #1;
        check(!bus.cache_stall, "rst_idle_stall", 32'(bus.cache_stall), 32'h0);
        check(!bus.mem_re && !bus.mem_we, "rst_idle_mem", {30'h0, bus.mem_re, bus.mem_we}, 32'h0);
        check(bus.cpu_rdata == 32'h0, "rst_idle_rdata", bus.cpu_rdata, 32'h0);
        bus.cpu_re = 1'b1; bus.cpu_addr = 32'h100;
        #1;
        check(bus.cache_stall, "rst_req_stall", 32'(bus.cache_stall), 32'h1);
        check(!bus.mem_re, "rst_req_mem_re", 32'(bus.mem_re), 32'h0);
        bus.cpu_re = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        idle(2);

        mem[32'h100] = 32'h11; mem[32'h104] = 32'h22; mem[32'h108] = 32'h33; mem[32'h10C] = 32'h44;
        do_req(1'b1, 1'b0, 32'h100, 32'h0, 0, -1, st, rd);
        check(st == 5, "cold_stall", 32'(st), 32'd5);
        check(rd == 32'h11, "cold_rdata", rd, 32'h11);

        do_req(1'b0, 1'b1, 32'h104, 32'hDEAD_BEEF, 0, -1, st, rd);
        check(st == 0, "store_hit_stall", 32'(st), 32'd0);
        do_req(1'b1, 1'b0, 32'h104, 32'h0, 0, -1, st, rd);
        check(rd == 32'hDEAD_BEEF, "store_hit_read", rd, 32'hDEAD_BEEF);

        do_req(1'b1, 1'b0, 32'h500, 32'h0, 0, -1, st, rd);
        check(st == 9, "dirty_stall", 32'(st), 32'd9);
        check(wlog.size() == 4, "dirty_wb_count", 32'(wlog.size()), 32'd4);
        if (wlog.size() == 4) begin
            check(wlog[0].addr == 32'h100 && wlog[0].data == 32'h11, "wb0", wlog[0].data, 32'h11);
            check(wlog[1].addr == 32'h104 && wlog[1].data == 32'hDEAD_BEEF, "wb1", wlog[1].data, 32'hDEAD_BEEF);
            check(wlog[3].addr == 32'h10C && wlog[3].data == 32'h44, "wb3", wlog[3].data, 32'h44);
        end

        do_req(1'b1, 1'b0, 32'h900, 32'h0, 3, -1, st, rd);
        check(st == 17, "wait3_stall", 32'(st), 32'd17);

        do_req(1'b1, 1'b0, 32'h2000, 32'h0, 0, 1, st, rd);
        idle(1);
        do_req(1'b1, 1'b0, 32'h2000, 32'h0, 0, -1, st, rd);
        check(st == 5, "after_rst_stall", 32'(st), 32'd5);

        do_req(1'b1, 1'b1, 32'h3004, 32'hCAFE_F00D, 0, -1, st, rd);
        check(st == 5, "rw_alloc_stall", 32'(st), 32'd5);
        check(rd == 32'h0, "rw_alloc_rdata", rd, 32'h0);
        do_req(1'b1, 1'b0, 32'h4000, 32'h0, 0, -1, st, rd);
        check(st == 9, "rw_dirty_stall", 32'(st), 32'd9);
        if (wlog.size() > 1)
            check(wlog[1].addr == 32'h3004 && wlog[1].data == 32'hCAFE_F00D, "rw_wb1", wlog[1].data, 32'hCAFE_F00D);
        else
            check(1'b0, "rw_wb_count", 32'(wlog.size()), 32'd4);

        for (int n = 0; n < 400; n++) begin
            addr = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 3) << 4) |
                   ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
            sel = int'($urandom_range(0, 3));
            do_req(sel != 1, sel == 1 || sel == 2, addr, $urandom, -1, -1, st, rd);
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
